// File: rtl/fft_peak_finder.sv
// fft_peak_finder
//
// Streaming post-processor for the FFT2048 output stream. For every
// N-point complex frame it computes the per-bin power re^2 + im^2. It
// reports the peak bin index, the peak power and the total frame energy
// once per frame. The datapath is fully pipelined and never stalls, so a
// new frame may start on the cycle after the previous frame's last sample.
//
// Configuration macro:
//   FFT_PEAK_BITREV_EN - when defined, the FFT is assumed to emit bins in
//                        bit-reversed order. peak_idx then reports the
//                        natural-order bin, which is the bit-reverse of
//                        the arrival index. Power and energy are unaffected.
//
// Ports:
//   clk          - single clock, rising edge
//   rst          - asynchronous active-high reset
//   in_valid     - sample strobe (FFT out_valid)
//   in_re/in_im  - signed real/imaginary sample (IN_W bits)
//   out_valid    - one-cycle pulse when a frame result is ready
//   peak_idx     - bin index of the maximum power (LOG2N bits)
//   peak_pow     - maximum power (2*IN_W bits, unsigned)
//   frame_energy - sum of all N powers (2*IN_W+LOG2N bits, unsigned)

module fft_peak_finder #(
    parameter int N     = 2048,
    parameter int LOG2N = 11,
    parameter int IN_W  = 26
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic signed [IN_W-1:0]    in_re,
    input  logic signed [IN_W-1:0]    in_im,
    output logic                      out_valid,
    output logic [LOG2N-1:0]          peak_idx,
    output logic [2*IN_W-1:0]         peak_pow,
    output logic [2*IN_W+LOG2N-1:0]   frame_energy
);

    localparam int SQ_W  = 2*IN_W-1;
    localparam int POW_W = 2*IN_W;
    localparam int EN_W  = 2*IN_W+LOG2N;

    // Arrival counter
    logic [LOG2N-1:0] cnt_q;

    // Stage 1: squares plus tags
    logic             s1Valid_q;
    logic             s1First_q;
    logic             s1Last_q;
    logic [LOG2N-1:0] s1Idx_q;
    logic [SQ_W-1:0]  s1Re2_q;
    logic [SQ_W-1:0]  s1Im2_q;

    // Stage 2: power plus tags
    logic             s2Valid_q;
    logic             s2First_q;
    logic             s2Last_q;
    logic [LOG2N-1:0] s2Idx_q;
    logic [POW_W-1:0] s2Pow_q;

    // Stage 3: running frame state
    logic [POW_W-1:0] maxPow_q, maxPow_d;
    logic [LOG2N-1:0] maxIdx_q, maxIdx_d;
    logic [EN_W-1:0]  energy_q, energy_d;
    logic             s3Last_q;

    // Magnitudes, zero-extended so the squares come out at full width.
    // -2^(IN_W-1) negates to itself, but read as unsigned that is the
    // correct magnitude 2^(IN_W-1).
    logic [IN_W-1:0]  magRe, magIm;
    logic [SQ_W-1:0]  magReExt, magImExt;
    logic [SQ_W-1:0]  re2, im2;
    logic [LOG2N-1:0] reportIdx;

    // Squares are taken on magnitudes. This keeps them unsigned and
    // exactly SQ_W bits wide, because (2^(IN_W-1))^2 = 2^(2*IN_W-2) fits.
    always_comb begin
        magRe    = in_re[IN_W-1] ? -in_re : in_re;
        magIm    = in_im[IN_W-1] ? -in_im : in_im;
        magReExt = {{(IN_W-1){1'b0}}, magRe};
        magImExt = {{(IN_W-1){1'b0}}, magIm};
        re2      = magReExt * magReExt;
        im2      = magImExt * magImExt;
    end

    // Index reported for a sample. In bit-reversed builds the conversion
    // is done once here, so the tie-break still follows arrival order.
`ifdef FFT_PEAK_BITREV_EN
    always_comb begin
        reportIdx = '0;
        for (int b = 0; b < LOG2N; b++) begin
            reportIdx[b] = cnt_q[LOG2N-1-b];
        end
    end
`else
    always_comb begin
        reportIdx = cnt_q;
    end
`endif

    // Counter and stage 1. The counter only moves on accepted samples.
    // The first/last tags are derived here and then travel with the data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            s1Valid_q <= 1'b0;
            s1First_q <= 1'b0;
            s1Last_q  <= 1'b0;
            s1Idx_q   <= '0;
            s1Re2_q   <= '0;
            s1Im2_q   <= '0;
        end else begin
            s1Valid_q <= in_valid;
            if (in_valid) begin
                cnt_q     <= cnt_q + LOG2N'(1);
                s1First_q <= (cnt_q == '0);
                s1Last_q  <= (cnt_q == LOG2N'(N-1));
                s1Idx_q   <= reportIdx;
                s1Re2_q   <= re2;
                s1Im2_q   <= im2;
            end
        end
    end

    // Stage 2: power sum. The extra MSB absorbs the carry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2Valid_q <= 1'b0;
            s2First_q <= 1'b0;
            s2Last_q  <= 1'b0;
            s2Idx_q   <= '0;
            s2Pow_q   <= '0;
        end else begin
            s2Valid_q <= s1Valid_q;
            if (s1Valid_q) begin
                s2First_q <= s1First_q;
                s2Last_q  <= s1Last_q;
                s2Idx_q   <= s1Idx_q;
                s2Pow_q   <= {1'b0, s1Re2_q} + {1'b0, s1Im2_q};
            end
        end
    end

    // Stage 3 next-state logic. A first-tagged sample restarts the frame
    // without comparing against the old one. Otherwise only a strictly
    // greater power wins, so ties keep the earliest-arriving bin.
    always_comb begin
        maxPow_d = maxPow_q;
        maxIdx_d = maxIdx_q;
        energy_d = energy_q;
        if (s2Valid_q) begin
            if (s2First_q) begin
                maxPow_d = s2Pow_q;
                maxIdx_d = s2Idx_q;
                energy_d = {{LOG2N{1'b0}}, s2Pow_q};
            end else begin
                if (s2Pow_q > maxPow_q) begin
                    maxPow_d = s2Pow_q;
                    maxIdx_d = s2Idx_q;
                end
                energy_d = energy_q + {{LOG2N{1'b0}}, s2Pow_q};
            end
        end
    end

    // Stage 3 registers. The last-tag is delayed one cycle so the output
    // copy happens from settled running state. A following frame may
    // overwrite the running state on that same edge without affecting
    // the copied results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            maxPow_q <= '0;
            maxIdx_q <= '0;
            energy_q <= '0;
            s3Last_q <= 1'b0;
        end else begin
            maxPow_q <= maxPow_d;
            maxIdx_q <= maxIdx_d;
            energy_q <= energy_d;
            s3Last_q <= s2Valid_q & s2Last_q;
        end
    end

    // Output registers. They hold their value between pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid    <= 1'b0;
            peak_idx     <= '0;
            peak_pow     <= '0;
            frame_energy <= '0;
        end else begin
            out_valid <= s3Last_q;
            if (s3Last_q) begin
                peak_idx     <= maxIdx_q;
                peak_pow     <= maxPow_q;
                frame_energy <= energy_q;
            end
        end
    end

endmodule

// File: doc/fft_peak_finder.md
# fft_peak_finder

Streaming post-processor placed directly downstream of the FFT2048 core. It consumes one 2048-point complex output frame (the FFT's `out_valid`/`O_re`/`O_im` stream) and computes per-bin power |X|² = re² + im². It reports the peak bin index, the peak power and the total frame energy once per frame. It feeds the spectrum-monitor/detection logic and is fully pipelined, so back-to-back frames are accepted with no stall.

## Interface
- `N`, 2048, points per frame (power of two)
- `LOG2N`, 11, log2(N); width of bin index
- `IN_W`, 26, signed width of incoming re/im samples
- `clk` input 1: single clock, rising edge
- `rst` input 1: reset. One clock; reset is asynchronous and active-high.
- `in_valid` input 1: sample strobe, driven by FFT `out_valid`
- `in_re` input IN_W: signed real part (FFT `O_re`)
- `in_im` input IN_W: signed imaginary part (FFT `O_im`)
- `out_valid` output 1: one-cycle pulse, result of a completed frame
- `peak_idx` output LOG2N: bin index of maximum power
- `peak_pow` output 2*IN_W: unsigned maximum power
- `frame_energy` output 2*IN_W+LOG2N: unsigned sum of all N powers

## Operation
- Sample counter `cnt` (LOG2N bits) advances only on cycles with `in_valid`=1. It wraps N-1 → 0. Sample with `cnt`=0 is first-of-frame; `cnt`=N-1 is last-of-frame.
- Gaps (`in_valid`=0 mid-frame) are legal. The counter and all running state hold during a gap.
- Pipeline with a valid bit and first/last tags per stage:
  - S1 registers re², im² (each 2*IN_W-1 bits unsigned) and the arrival index.
  - S2 registers pow = re² + im² (2*IN_W bits, no overflow possible; max (-2^25)²·2 = 2^51).
  - S3 updates the running max/index/energy.
- Running max: on a first-tagged sample, max, index and energy are loaded from that sample and are not compared against the old frame. Otherwise the sample replaces the max only if pow is strictly greater than max, so ties keep the earliest-arriving bin. Energy accumulates without saturation; the width covers N × max pow exactly.
- On a last-tagged sample, S3 also copies the final values into the output registers and pulses `out_valid`.
- Because the first/last tags travel with the data, frame k+1 may begin the cycle after frame k's last sample.
- Outputs hold their value between pulses.
- Reset (any time, including mid-frame): `cnt`, all pipeline valid bits, running state and all outputs are cleared to 0. A partial frame is discarded with no `out_valid`, and the next `in_valid` sample is treated as `cnt`=0.

## Timing
- Reset values: `out_valid`=0, `peak_idx`=0, `peak_pow`=0, `frame_energy`=0.
- Latency: if the last sample is sampled at edge E, `out_valid`=1 with final outputs is registered at edge E+3. It stays high for exactly one cycle.
- Throughput: 1 sample/cycle sustained. There is no back-pressure; the block must always accept.
- Two consecutive `out_valid` pulses are at least N cycles apart.

## Configuration
- `FFT_PEAK_BITREV_EN`:
  - Defined: the FFT emits bins in bit-reversed order. `peak_idx` reports the natural-order bin, i.e. the bit-reverse of the LOG2N-bit arrival index. Tie-break stays earliest-arriving.
  - Undefined: `peak_idx` = arrival index.
- Power and energy results are identical in both builds.

## Test plan
- Impulse: frame all zero except arrival 5 with re=1000, im=0 → `peak_pow`=1000000, `frame_energy`=1000000. `peak_idx`=5, or 1280 with `FFT_PEAK_BITREV_EN`. `out_valid` arrives 3 edges after the last sample.
- Extremes: all samples re=im=-2^25 → `peak_pow`=2^51, `frame_energy`=2^62, `peak_idx`=0 (tie, earliest). All-zero frame → all outputs 0 with a pulse.
- Ties and gaps: arrivals 10 and 700 both (3,4) → pow 25, `peak_idx`=10. Random 1–5-cycle `in_valid` gaps → identical results and exactly one pulse.
- Back-to-back frames: frame A peak at arrival 2047 (pow 4), frame B (starting next cycle) peak at 0 (pow 1). Expected: A → idx 2047, pow 4; B → idx 0, pow 1. Frame B's energy must exclude A.
- Reset mid-frame: assert `rst` after 1000 samples, then send a full frame → exactly one pulse, with results from the new frame only. During reset all outputs read 0 asynchronously.
